// File: rtl/alarm_supervisor_if.sv
// alarm_supervisor_if
//   UART byte-side bundle between the alarm supervisor and the UART
//   receiver/transmitter pair.
//
//   Signals:
//     cmd_arr   receiver -> supervisor  one-cycle strobe, cmd_data valid
//     cmd_data  receiver -> supervisor  received command byte
//     tx_ready  transmitter -> sup.     transmitter idle, may accept a byte
//     tx_send   supervisor -> tx        one-cycle start pulse
//     tx_data   supervisor -> tx        byte to send, stable until tx_finish
//     tx_finish transmitter -> sup.     one-cycle byte-done strobe
//
//   Handshake: a byte is handed over on the single cycle where tx_send=1,
//   which the supervisor only raises while tx_ready=1. tx_data is valid on
//   that cycle and stays unchanged until the matching tx_finish pulse; the
//   next byte is not offered before that pulse. tx_finish with no byte
//   outstanding has no effect.
//
//   Modports: slave = supervisor side, master = UART side.
interface alarm_supervisor_if;
  logic       cmd_arr;
  logic [7:0] cmd_data;
  logic       tx_ready;
  logic       tx_send;
  logic       tx_finish;
  logic [7:0] tx_data;

  modport slave (
    input  cmd_arr, cmd_data, tx_ready, tx_finish,
    output tx_send, tx_data
  );

  modport master (
    output cmd_arr, cmd_data, tx_ready, tx_finish,
    input  tx_send, tx_data
  );
endinterface

// File: rtl/alarm_supervisor.sv
// alarm_supervisor
//   N-channel threshold supervisor. On each sample tick every channel is
//   compared with its threshold; HOLD consecutive exceeding ticks while
//   armed trip the channel and raise a sticky alarm that sounds the buzzer.
//   Arm/disarm bytes arrive over the UART receive strobe, and every accepted
//   tick launches a status/sample frame over the UART byte handshake.
//
//   Optional feature (macro ALARM_REARM_EN): while armed and alarmed,
//   REARM_TICKS consecutive ticks with all debounce counters at zero clear
//   the alarm and trip flags. Without the macro the alarm is sticky until a
//   command or reset, and REARM_TICKS does not exist.
//
//   Ports:
//     Clock, Reset   clock, synchronous active-low reset
//     tick           one-cycle sample strobe
//     sample, thresh NCH*DW, channel i at [i*DW +: DW], unsigned
//     dir            per channel: 1 exceed on sample>thresh, 0 on sample<thresh
//     uart           alarm_supervisor_if.slave (command rx + byte tx)
//     armed, alarm   system armed / sticky alarm
//     trip_mask      sticky per-channel trip flags
//     buzz_n         buzzer drive, active low
//     fsm_state      frame FSM state (IDLE=0, LOAD=1, WAIT_RDY=2, WAIT_FIN=3)
module alarm_supervisor #(
  parameter int         NCH        = 4,
  parameter int         DW         = 16,
  parameter int         HOLD       = 3,
  parameter logic [7:0] CMD_ARM    = 8'h88,
  parameter logic [7:0] CMD_DISARM = 8'h99,
  parameter logic [7:0] HDR        = 8'h55
`ifdef ALARM_REARM_EN
  , parameter int       REARM_TICKS = 25
`endif
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic                tick,
  input  logic [NCH*DW-1:0]   sample,
  input  logic [NCH*DW-1:0]   thresh,
  input  logic [NCH-1:0]      dir,
  alarm_supervisor_if.slave   uart,
  output logic                armed,
  output logic                alarm,
  output logic [NCH-1:0]      trip_mask,
  output logic                buzz_n,
  output logic [1:0]          fsm_state
);

  localparam int         L     = 3 + NCH * DW / 8;
  localparam int         FW    = 8 * L;
  localparam int         IW    = $clog2(L);
  localparam logic [7:0] HOLD8 = 8'(HOLD);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] LOAD     = 2'd1;
  localparam logic [1:0] WAIT_RDY = 2'd2;
  localparam logic [1:0] WAIT_FIN = 2'd3;

  logic [7:0]     cnt     [NCH];
  logic [7:0]     cnt_nxt [NCH];
  logic [NCH-1:0] exceed, hit;
  logic           is_arm, is_dis;
  logic           armed_nxt, alarm_nxt;
  logic [NCH-1:0] trip_nxt;

  logic [1:0]     state;
  logic [IW-1:0]  idx;
  logic [FW-1:0]  frame_q, frame_w;
  logic [7:0]     trip_byte;
  logic           tx_send_q;
  logic [7:0]     tx_data_q;

`ifdef ALARM_REARM_EN
  localparam int QW = $clog2(REARM_TICKS + 1);
  logic [QW-1:0] quiet, quiet_nxt;
  logic          any_nz;
`endif

  assign uart.tx_send = tx_send_q;
  assign uart.tx_data = tx_data_q;
  assign fsm_state    = state;

  // Debounce, trip and command handling. A command in the same cycle as a
  // trip takes priority: no trip is recorded, and ARM also zeroes counters.
  always_comb begin
    is_arm    = uart.cmd_arr && (uart.cmd_data == CMD_ARM);
    is_dis    = uart.cmd_arr && (uart.cmd_data == CMD_DISARM);
    armed_nxt = armed;
    alarm_nxt = alarm;
    trip_nxt  = trip_mask;
    for (int i = 0; i < NCH; i++) begin
      exceed[i]  = dir[i] ? (sample[i*DW +: DW] > thresh[i*DW +: DW])
                          : (sample[i*DW +: DW] < thresh[i*DW +: DW]);
      cnt_nxt[i] = cnt[i];
      hit[i]     = 1'b0;
      if (tick) begin
        cnt_nxt[i] = exceed[i] ? ((cnt[i] >= HOLD8) ? HOLD8 : cnt[i] + 8'd1)
                               : 8'd0;
        hit[i]     = (cnt_nxt[i] == HOLD8);
      end
    end
    if (is_arm) begin
      armed_nxt = 1'b1;
      alarm_nxt = 1'b0;
      trip_nxt  = '0;
      for (int i = 0; i < NCH; i++) cnt_nxt[i] = 8'd0;
    end else if (is_dis) begin
      armed_nxt = 1'b0;
      alarm_nxt = 1'b0;
      trip_nxt  = '0;
    end else if (armed) begin
      trip_nxt = trip_mask | hit;
      if (|hit) alarm_nxt = 1'b1;
    end
`ifdef ALARM_REARM_EN
    any_nz = 1'b0;
    for (int i = 0; i < NCH; i++) if (cnt_nxt[i] != 8'd0) any_nz = 1'b1;
    quiet_nxt = quiet;
    if (is_arm || is_dis || !(armed && alarm)) begin
      quiet_nxt = '0;
    end else if (tick) begin
      if (any_nz) begin
        quiet_nxt = '0;
      end else if (quiet == QW'(REARM_TICKS - 1)) begin
        quiet_nxt = '0;
        alarm_nxt = 1'b0;
        trip_nxt  = '0;
      end else begin
        quiet_nxt = quiet + QW'(1);
      end
    end
`endif
  end

  // Frame image, MSB byte transmitted first: header, flags, trip mask,
  // then channel 0..NCH-1 samples each MSB byte first.
  always_comb begin
    trip_byte             = '0;
    trip_byte[NCH-1:0]    = trip_mask;
    frame_w               = '0;
    frame_w[FW-1  -: 8]   = HDR;
    frame_w[FW-9  -: 8]   = {armed, alarm, 6'b0};
    frame_w[FW-17 -: 8]   = trip_byte;
    for (int i = 0; i < NCH; i++)
      frame_w[(NCH-1-i)*DW +: DW] = sample[i*DW +: DW];
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      armed     <= 1'b0;
      alarm     <= 1'b0;
      trip_mask <= '0;
      buzz_n    <= 1'b1;
      for (int i = 0; i < NCH; i++) cnt[i] <= 8'd0;
`ifdef ALARM_REARM_EN
      quiet     <= '0;
`endif
    end else begin
      armed     <= armed_nxt;
      alarm     <= alarm_nxt;
      trip_mask <= trip_nxt;
      buzz_n    <= ~alarm_nxt;
      for (int i = 0; i < NCH; i++) cnt[i] <= cnt_nxt[i];
`ifdef ALARM_REARM_EN
      quiet     <= quiet_nxt;
`endif
    end
  end

  // Frame FSM. Ticks outside IDLE are not reported. The snapshot is a
  // shift register; the top byte is the next one to send.
  always_ff @(posedge Clock) begin
    if (!Reset) begin
      state     <= IDLE;
      idx       <= '0;
      frame_q   <= '0;
      tx_send_q <= 1'b0;
      tx_data_q <= 8'd0;
    end else begin
      tx_send_q <= 1'b0;
      case (state)
        IDLE: if (tick) state <= LOAD;
        LOAD: begin
          frame_q <= frame_w;
          idx     <= '0;
          state   <= WAIT_RDY;
        end
        WAIT_RDY: if (uart.tx_ready) begin
          tx_send_q <= 1'b1;
          tx_data_q <= frame_q[FW-1 -: 8];
          frame_q   <= frame_q << 8;
          state     <= WAIT_FIN;
        end
        WAIT_FIN: if (uart.tx_finish) begin
          if (idx == IW'(L - 1)) begin
            state <= IDLE;
          end else begin
            idx   <= idx + IW'(1);
            state <= WAIT_RDY;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alarm_supervisor.sv
// tb_alarm_supervisor
//   Bench for alarm_supervisor (NCH=4, DW=16, HOLD=3). A reference model
//   tracks run lengths of exceeding ticks per channel, arm/alarm state and
//   whether a frame is in flight; every accepted tick pushes the expected
//   frame bytes into exp_q and a separate monitor pops them on tx_send.
module tb_alarm_supervisor;
  localparam int         NCH = 4;
  localparam int         DW  = 16;
  localparam int         HOLD = 3;
  localparam int         L   = 3 + NCH * DW / 8;
  localparam logic [7:0] ARM = 8'h88;
  localparam logic [7:0] DIS = 8'h99;
  localparam logic [7:0] HDR = 8'h55;
`ifdef ALARM_REARM_EN
  localparam int         REARM = 25;
`endif

  // ---------------- clock / reset ----------------
  logic Clock = 1'b0;
  logic Reset = 1'b0;
  always #5 Clock = ~Clock;

  logic                tick;
  logic [NCH*DW-1:0]   sample, thresh;
  logic [NCH-1:0]      dir;
  logic                armed, alarm, buzz_n;
  logic [NCH-1:0]      trip_mask;
  logic [1:0]          fsm_state;

  alarm_supervisor_if uif();

  alarm_supervisor #(.NCH(NCH), .DW(DW), .HOLD(HOLD),
                     .CMD_ARM(ARM), .CMD_DISARM(DIS), .HDR(HDR)) dut (
    .Clock(Clock), .Reset(Reset), .tick(tick),
    .sample(sample), .thresh(thresh), .dir(dir),
    .uart(uif.slave),
    .armed(armed), .alarm(alarm), .trip_mask(trip_mask),
    .buzz_n(buzz_n), .fsm_state(fsm_state)
  );

  // ---------------- model state ----------------
  int             total = 0;
  int             bad = 0;
  logic [7:0]     exp_q[$];
  logic [DW-1:0]  s_ch [NCH];
  logic [DW-1:0]  t_ch [NCH];
  bit             m_armed, m_alarm;
  logic [NCH-1:0] m_trip;
  int             run [NCH];
  int             quiet;
  int             bytes_left, fin_cnt, fin_delay, send_count;
  bit             ready_mode, spurious_en, fin_real, prev_send;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_armed = 0; m_alarm = 0; m_trip = '0; quiet = 0;
    for (int i = 0; i < NCH; i++) run[i] = 0;
    exp_q.delete();
    bytes_left = 0;
    fin_cnt = 0;
  endtask

  // Effect of the currently driven inputs at the coming rising edge.
  task automatic model_edge();
    bit pa, pl, is_arm, is_dis, ex;
    logic [7:0] tb8;
    if (!Reset) begin
      model_reset();
      return;
    end
    pa = m_armed;
    pl = m_alarm;
    is_arm = uif.cmd_arr && uif.cmd_data == ARM;
    is_dis = uif.cmd_arr && uif.cmd_data == DIS;
    if (tick)
      for (int i = 0; i < NCH; i++) begin
        ex = dir[i] ? (s_ch[i] > t_ch[i]) : (s_ch[i] < t_ch[i]);
        run[i] = ex ? run[i] + 1 : 0;
      end
    if (is_arm) begin
      m_armed = 1; m_alarm = 0; m_trip = '0;
      for (int i = 0; i < NCH; i++) run[i] = 0;
    end else if (is_dis) begin
      m_armed = 0; m_alarm = 0; m_trip = '0;
    end else if (tick && pa) begin
      for (int i = 0; i < NCH; i++)
        if (run[i] >= HOLD) begin
          m_trip[i] = 1'b1;
          m_alarm = 1;
        end
    end
`ifdef ALARM_REARM_EN
    if (is_arm || is_dis || !(pa && pl)) quiet = 0;
    else if (tick) begin
      bit nz = 0;
      for (int i = 0; i < NCH; i++) if (run[i] != 0) nz = 1;
      if (nz) quiet = 0;
      else begin
        quiet++;
        if (quiet == REARM) begin
          m_alarm = 0; m_trip = '0; quiet = 0;
        end
      end
    end
`else
    if (pl) quiet = 0;
`endif
    if (tick && bytes_left == 0) begin
      bytes_left = L;
      exp_q.push_back(HDR);
      exp_q.push_back({m_armed, m_alarm, 6'b0});
      tb8 = '0;
      tb8[NCH-1:0] = m_trip;
      exp_q.push_back(tb8);
      for (int c = 0; c < NCH; c++)
        for (int b = DW / 8 - 1; b >= 0; b--)
          exp_q.push_back(s_ch[c][b*8 +: 8]);
    end
    if (fin_real) bytes_left--;
  endtask

  // ---------------- driver ----------------
  // Called at a falling edge: checks state from the last rising edge,
  // drives inputs for the next one, advances the model, waits one cycle.
  task automatic cyc(input bit t, input bit cv = 0, input logic [7:0] cb = 8'h00);
    check("state{armed,alarm,trip,buzz_n}", {armed, alarm, trip_mask, buzz_n},
          {m_armed, m_alarm, m_trip, ~m_alarm});
    fin_real = 0;
    uif.tx_finish = 0;
    if (Reset && uif.tx_send) fin_cnt = (fin_delay > 0) ? fin_delay : $urandom_range(1, 4);
    if (fin_cnt > 0) begin
      fin_cnt--;
      if (fin_cnt == 0) begin
        uif.tx_finish = 1;
        fin_real = 1;
      end
    end else if (spurious_en && !uif.tx_send && $urandom_range(0, 7) == 0) begin
      uif.tx_finish = 1;
    end
    uif.tx_ready = ready_mode ? 1'b1 : ($urandom_range(0, 3) != 0);
    tick = t;
    uif.cmd_arr = cv;
    uif.cmd_data = cb;
    for (int i = 0; i < NCH; i++) begin
      sample[i*DW +: DW] = s_ch[i];
      thresh[i*DW +: DW] = t_ch[i];
    end
    model_edge();
    @(negedge Clock);
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((bytes_left != 0 || exp_q.size() != 0) && n < 3000) begin
      cyc(0);
      n++;
    end
    total++;
    if (n >= 3000) begin
      bad++;
      $display("FAIL drain_timeout: bytes_left=%0d queued=%0d", bytes_left, exp_q.size());
    end
    cyc(0);
    cyc(0);
  endtask

  task automatic ticks(input int n, input int gap);
    for (int k = 0; k < n; k++) begin
      cyc(1);
      repeat (gap) cyc(0);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(posedge Clock) begin
    #1;
    if (uif.tx_send) begin
      send_count++;
      check("send_single_pulse", prev_send, 1'b0);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_send: tx_data=%0h with no byte expected", uif.tx_data);
      end else begin
        logic [7:0] e;
        e = exp_q.pop_front();
        check("tx_data", uif.tx_data, e);
      end
    end
    prev_send = uif.tx_send;
  end

  // ---------------- stimulus ----------------
  initial begin
    int base;
    bit last_tick;
    send_count = 0; prev_send = 0;
    fin_delay = 0; ready_mode = 1; spurious_en = 0; fin_real = 0;
    tick = 0; dir = '1;
    uif.cmd_arr = 0; uif.cmd_data = 0; uif.tx_ready = 1; uif.tx_finish = 0;
    for (int i = 0; i < NCH; i++) begin
      s_ch[i] = '0;
      t_ch[i] = 16'd200;
      sample[i*DW +: DW] = '0;
      thresh[i*DW +: DW] = 16'd200;
    end
    model_reset();
    @(negedge Clock);

    // reset state
    repeat (3) cyc(0);
    check("rst_fsm_idle", fsm_state, 2'd0);
    check("rst_buzz_n", buzz_n, 1'b1);
    check("rst_tx_send", uif.tx_send, 1'b0);
    check("rst_tx_data", uif.tx_data, 8'h00);
    Reset = 1;
    cyc(0);

    // arm, then ch1 exceeds for HOLD ticks
    cyc(0, 1, ARM);
    s_ch[1] = 16'd300;
    for (int k = 0; k < 3; k++) begin
      cyc(1);
      cyc(0);
      if (k < 2) check("no_trip_before_hold", alarm, 1'b0);
    end
    check("trip_alarm", alarm, 1'b1);
    check("trip_mask", trip_mask, 4'b0010);
    check("trip_buzz_n", buzz_n, 1'b0);
    check("trip_armed", armed, 1'b1);

    // debounce broken by one quiet tick; equality never exceeds
    cyc(0, 1, ARM);
    s_ch[1] = 0;
    foreach (s_ch[i]) ;
    for (int k = 0; k < 5; k++) begin
      s_ch[0] = (k == 2) ? 16'd100 : 16'd250;
      cyc(1);
      cyc(0);
    end
    check("debounce_no_trip", alarm, 1'b0);
    s_ch[0] = 16'd200;
    ticks(5, 1);
    check("equal_no_trip", alarm, 1'b0);
    // dir=0 channel trips below threshold, equality still not
    s_ch[0] = 0;
    dir[2] = 1'b0;
    s_ch[2] = 16'd50;
    ticks(3, 1);
    check("dir0_trip_mask", trip_mask, 4'b0100);
    s_ch[2] = 16'd200;
    dir[2] = 1'b1;

    // disarm on the tick that reaches HOLD; junk byte ignored
    cyc(0, 1, ARM);
    s_ch[0] = 16'd250;
    ticks(2, 1);
    cyc(1, 1, DIS);
    check("disarm_wins_armed", armed, 1'b0);
    check("disarm_wins_alarm", alarm, 1'b0);
    check("disarm_wins_mask", trip_mask, 4'b0000);
    cyc(0, 1, 8'h42);
    check("junk_cmd_armed", armed, 1'b0);
    check("junk_cmd_alarm", alarm, 1'b0);
    // arm on a tick clears the (saturated) counter: HOLD more ticks to trip
    cyc(1, 1, ARM);
    cyc(0);
    ticks(2, 1);
    check("arm_clears_cnt", alarm, 1'b0);
    ticks(1, 1);
    check("arm_then_trip", alarm, 1'b1);

    // directed frame: 55 80 00 12 34 00 00 00 00 AB CD
    s_ch[0] = 16'h1234; s_ch[1] = 16'h0000; s_ch[2] = 16'h0000; s_ch[3] = 16'hABCD;
    for (int i = 0; i < NCH; i++) t_ch[i] = 16'hFFFF;
    dir = '1;
    cyc(0, 1, ARM);
    wait_drain();
    fin_delay = 3;
    base = send_count;
    cyc(1);
    repeat (6) cyc(0);
    cyc(1);            // tick while busy: not reported
    wait_drain();
    check("frame_send_count", send_count - base, L);

    // reset in the middle of a frame with the alarm sounding
    for (int i = 0; i < NCH; i++) t_ch[i] = 16'd200;
    ticks(3, 1);
    wait_drain();
    check("pre_reset_alarm", alarm, 1'b1);
    cyc(1);
    repeat (15) cyc(0);
    Reset = 0;
    repeat (2) cyc(0);
    Reset = 1;
    check("rst_mid_fsm_idle", fsm_state, 2'd0);
    check("rst_mid_buzz_n", buzz_n, 1'b1);
    check("rst_mid_armed", armed, 1'b0);
    base = send_count;
    repeat (25) cyc(0);
    check("rst_mid_no_send", send_count - base, 0);

    // randomized traffic
    fin_delay = 0; ready_mode = 0; spurious_en = 1;
    last_tick = 0;
    for (int k = 0; k < 600; k++) begin
      bit t, cv;
      logic [7:0] cb;
      int r;
      t = !last_tick && ($urandom_range(0, 2) == 0);
      if (t && $urandom_range(0, 1) == 0) begin
        int c = $urandom_range(0, NCH - 1);
        if ($urandom_range(0, 4) == 0) begin
          s_ch[c] = DW'($urandom);
          t_ch[c] = DW'($urandom);
        end else begin
          s_ch[c] = DW'($urandom_range(0, 6));
          t_ch[c] = DW'($urandom_range(0, 6));
        end
        dir[c] = $urandom_range(0, 1);
      end
      r = $urandom_range(0, 39);
      cv = (r < 4);
      cb = (r < 2) ? ARM : (r == 2) ? DIS : 8'($urandom);
      cyc(t, cv, cb);
      last_tick = t;
    end
    wait_drain();

    // alarm stickiness over many quiet ticks
    spurious_en = 0; ready_mode = 1;
    for (int i = 0; i < NCH; i++) begin
      s_ch[i] = 0;
      t_ch[i] = 16'd200;
    end
    dir = '1;
    cyc(0, 1, ARM);
    s_ch[1] = 16'd300;
    ticks(3, 1);
    check("sticky_trip", alarm, 1'b1);
    s_ch[1] = 0;
    ticks(100, 1);
`ifdef ALARM_REARM_EN
    check("rearm_alarm", alarm, 1'b0);
`else
    check("sticky_alarm", alarm, 1'b1);
`endif
    check("sticky_armed", armed, 1'b1);
    wait_drain();
    check("queue_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // hard stop in case a wait loop misbehaves
  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/alarm_supervisor.md
Name: alarm_supervisor

Overview:
- N-channel threshold supervisor for the alarm node. Sits between the sensor front-ends (ALS, ACL2, ultrasonic distance) and the UART byte transmitter/receiver.
- Debounces per-channel threshold crossings on a sample strobe and latches a sticky alarm that drives the buzzer.
- Decodes arm/disarm command bytes and streams a periodic status/sample frame through the UART byte handshake.
- Successor to the fixed single-purpose control loop: channel count, sample width, debounce depth and command codes are parametrised.

Parameters:
- NCH, 4: number of channels, 1..8.
- DW, 16: sample width per channel, multiple of 8, 8..32.
- HOLD, 3: consecutive exceeding ticks needed to trip, 1..255.
- CMD_ARM, 8'h88: command byte that arms the system.
- CMD_DISARM, 8'h99: command byte that disarms the system.
- HDR, 8'h55: frame header byte.
- REARM_TICKS, 25: quiet ticks before auto-clear. Used only with ALARM_REARM_EN.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  synchronous, active-low reset.
- tick  in  1  one-cycle sample strobe (5 Hz enable).
- sample  in  NCH*DW  channel i at [i*DW +: DW], unsigned.
- thresh  in  NCH*DW  per-channel threshold, same packing.
- dir  in  NCH  1: exceed when sample>thresh; 0: exceed when sample<thresh.
- cmd_arr  in  1  one-cycle strobe, received byte valid.
- cmd_data  in  8  received byte.
- tx_ready  in  1  transmitter idle.
- tx_send  out  1  one-cycle start pulse.
- tx_finish  in  1  one-cycle byte-done strobe.
- tx_data  out  8  byte to transmit.
- armed  out  1  system armed.
- alarm  out  1  sticky alarm.
- trip_mask  out  NCH  sticky per-channel trip flags.
- buzz_n  out  1  buzzer drive, active-low (0 = sounding).

Behaviour:
- Reset (Reset==0 at a Clock edge): armed=0, alarm=0, trip_mask=0, all counters=0, buzz_n=1, tx_send=0, tx_data=0, frame FSM=IDLE. A frame in flight is abandoned with no further tx_send.
- Commands, on cmd_arr:
  - CMD_ARM sets armed=1 and clears alarm, trip_mask and counters.
  - CMD_DISARM sets armed=0 and clears alarm and trip_mask.
  - All other bytes are ignored.
- Per channel on tick:
  - exceed_i compares the full DW bits, unsigned. Equality is never an exceed.
  - cnt_i (8-bit) increments on exceed, saturating at HOLD. It clears to 0 on non-exceed.
  - When cnt_i reaches HOLD and armed=1, trip_mask[i] and alarm set on the same edge.
  - Counters run while disarmed, but no trip is recorded.
- Simultaneous command and trip in one cycle: the command wins. No trip is recorded that cycle; ARM also clears the counters.
- buzz_n = ~alarm, registered; it follows alarm with no extra latency.
- Frame FSM states: IDLE, LOAD, WAIT_RDY, WAIT_FIN.
  - IDLE -> LOAD on tick. LOAD snapshots armed, alarm, trip_mask and sample for the whole frame.
  - A tick arriving while not IDLE is dropped for reporting. Trip logic still processes it.
- Frame layout, L = 3 + NCH*DW/8 bytes:
  - HDR.
  - {armed, alarm, 6'b0}.
  - trip_mask zero-extended to 8 bits.
  - Channel 0..NCH-1 samples, each MSB byte first.
- Byte handshake:
  - In WAIT_RDY with tx_ready=1: assert tx_send for exactly one cycle, tx_data valid on that same cycle, then go to WAIT_FIN.
  - tx_data is held stable until tx_finish.
  - On tx_finish, advance the byte index. After the last byte, go to IDLE; otherwise go to WAIT_RDY.
  - tx_finish seen outside WAIT_FIN is ignored.
- Worst-case frame latency is unbounded (waits on tx_ready). No timeout.

Optional Feature:
- Macro ALARM_REARM_EN.
- When defined: while armed and alarm=1, a quiet-tick counter counts ticks on which every cnt_i==0. Any nonzero cnt_i on a tick resets the quiet count. After REARM_TICKS consecutive quiet ticks, alarm and trip_mask clear; armed stays 1.
- When undefined: alarm and trip_mask are sticky until CMD_ARM, CMD_DISARM or reset. No quiet counter is synthesised.

Test Plan:
- Arm, trip: send cmd 8'h88; hold ch1 sample=300, thresh=200, dir=1 for 3 ticks -> after 3rd tick alarm=1, trip_mask=4'b0010, buzz_n=0.
- Debounce, boundary: ch0 exceeds on 2 ticks, drops 1, exceeds 2 -> no trip. sample==thresh for 5 ticks -> no trip.
- Disarm wins: cmd_arr with 8'h99 on the same cycle cnt reaches HOLD -> armed=0, alarm=0, trip_mask=0. Then 8'h42 -> no state change.
- Frame: NCH=4, DW=16, armed, no alarm, samples 16'h1234, 0, 0, 16'hABCD, tx_ready tied 1, tx_finish 3 cycles after each send -> bytes 55 80 00 12 34 00 00 00 00 AB CD: 11 sends, one pulse each.
- Busy/reset: tick during frame -> no second frame; Reset low mid-frame -> tx_send stays 0, FSM IDLE, buzz_n=1.
- ALARM_REARM_EN, REARM_TICKS=4: trip, then 4 quiet ticks -> alarm=0, armed=1. Without the macro, alarm stays 1 after 100 quiet ticks.
